sample_pacer: RTL and testbench

//  Sample-strobe sequencer clocked by the rPLL CLKOUT (36 MHz from 27 MHz ref).

---
 rtl/sample_pacer.sv | 195 +++++++++++++++++++
 tb/tb_sample_pacer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sample_pacer.sv
// sample_pacer: post-PLL sample-strobe sequencer.
//   After reset release (through a 2-flop synchroniser) it waits a fixed
//   settle window, then emits bursts of one-cycle strobes at a programmable
//   period. Bursts can be aborted with stop.
// Ports:
//   clk, rst            - PLL output clock; async active-high reset
//   start, stop         - burst request (IDLE only) / abort request (RUN only)
//   period, count       - strobe spacing (0 treated as 1) and strobes per burst
//   ready, busy         - idle-and-accepting / burst in progress
//   strobe, sample_idx  - one-cycle sample pulse and its index in the burst
//   done, aborted       - end-of-burst pulse / last burst was stopped
module sample_pacer #(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned PERIOD_W      = 16,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [COUNT_W-1:0]  count,
    output logic                ready,
    output logic                busy,
    output logic                strobe,
    output logic [COUNT_W-1:0]  sample_idx,
    output logic                done,
    output logic                aborted
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_SETTLE = 2'd0,
        S_IDLE   = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Reset-release synchroniser: bit 1 holds the FSM until the 2nd edge after rst falls
    logic [1:0] rst_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    logic rst_hold;
    assign rst_hold = rst_sync_q[1];

    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [PERIOD_W-1:0]   per_cnt_q, per_cnt_d;
    logic [COUNT_W-1:0]    rem_q, rem_d;
    logic [COUNT_W-1:0]    idx_q, idx_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  strobe_q, strobe_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;

    // Period of zero behaves as back-to-back strobes
    logic [PERIOD_W-1:0]   period_eff;
    assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
            period_q     <= '0;
            per_cnt_q    <= '0;
            rem_q        <= '0;
            idx_q        <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            period_q     <= period_d;
            per_cnt_q    <= per_cnt_d;
            rem_q        <= rem_d;
            idx_q        <= idx_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            strobe_q     <= strobe_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        period_d     = period_q;
        per_cnt_d    = per_cnt_q;
        rem_d        = rem_q;
        idx_d        = idx_q;
        ready_d      = ready_q;
        busy_d       = busy_q;
        strobe_d     = 1'b0;
        done_d       = 1'b0;
        aborted_d    = aborted_q;

        if (rst_hold) begin
            state_d      = S_SETTLE;
            settle_cnt_d = '0;
            period_d     = '0;
            per_cnt_d    = '0;
            rem_d        = '0;
            idx_d        = '0;
            ready_d      = 1'b0;
            busy_d       = 1'b0;
            aborted_d    = 1'b0;
        end else begin
            case (state_q)
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_d      = S_IDLE;
                        settle_cnt_d = '0;
                        ready_d      = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end

                S_IDLE: begin
                    ready_d = 1'b1;
                    if (start) begin
                        period_d  = period_eff;
                        aborted_d = 1'b0;
                        ready_d   = 1'b0;
                        if (count != '0) begin
                            state_d   = S_RUN;
                            busy_d    = 1'b1;
                            strobe_d  = 1'b1;
                            idx_d     = '0;
                            rem_d     = count - COUNT_W'(1);
                            per_cnt_d = period_eff - PERIOD_W'(1);
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    // rem_q counts strobes still owed after the latest one
                    if (stop) begin
                        state_d   = S_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        aborted_d = 1'b1;
                    end else if (rem_q == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (per_cnt_q == '0) begin
                        strobe_d  = 1'b1;
                        idx_d     = idx_q + COUNT_W'(1);
                        rem_d     = rem_q - COUNT_W'(1);
                        per_cnt_d = period_q - PERIOD_W'(1);
                    end else begin
                        per_cnt_d = per_cnt_q - PERIOD_W'(1);
                    end
                end

                S_DONE: begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end

                default: begin
                    state_d = S_SETTLE;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign strobe     = strobe_q;
    assign sample_idx = idx_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_sample_pacer.sv
// tb_sample_pacer: directed and randomized bursts checked against a
// cycle-offset reference model (strobe i at offset 1+P*i, done after the
// last strobe or one cycle after stop).
module tb_sample_pacer;

    localparam int unsigned SETTLE   = 1024;
    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned COUNT_W  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic [COUNT_W-1:0]  count = '0;
    logic                ready, busy, strobe, done, aborted;
    logic [COUNT_W-1:0]  sample_idx;

    int n_checks = 0;
    int n_pass   = 0;

    sample_pacer #(
        .SETTLE_CYCLES(SETTLE),
        .PERIOD_W     (PERIOD_W),
        .COUNT_W      (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .count     (count),
        .ready     (ready),
        .busy      (busy),
        .strobe    (strobe),
        .sample_idx(sample_idx),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Release reset at a negedge with start held high; ready must appear
    // exactly 2+SETTLE edges later and no strobe may occur before it.
    task automatic release_and_settle();
        logic saw_strobe;
        logic early_ready;
        saw_strobe  = 1'b0;
        early_ready = 1'b0;
        start  = 1'b1;
        period = PERIOD_W'(1);
        count  = COUNT_W'(2);
        rst    = 1'b0;
        for (int e = 1; e <= int'(SETTLE) + 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (strobe === 1'b1 || busy === 1'b1) saw_strobe = 1'b1;
            if (e < int'(SETTLE) + 2 && ready !== 1'b0) early_ready = 1'b1;
            if (e == int'(SETTLE) + 1) chk("ready_before_settle_end", 32'(ready), 32'd0);
        end
        chk("ready_at_settle_end", 32'(ready), 32'd1);
        chk("no_early_ready", 32'(early_ready), 32'd0);
        chk("no_strobe_in_settle", 32'(saw_strobe), 32'd0);
        start = 1'b0;
    endtask

    // One burst from IDLE. stop_at>0 drives stop during that cycle offset.
    task automatic burst(input int p, input int n, input int stop_at, input bit noise);
        int pe, last, done_j, ab_exp, strobe_exp;
        pe     = (p == 0) ? 1 : p;
        last   = (n == 0) ? 0 : 1 + pe * (n - 1);
        ab_exp = 0;
        if (n == 0) begin
            done_j = 1;
        end else if (stop_at >= 1 && stop_at <= last) begin
            done_j = stop_at + 1;
            ab_exp = 1;
            last   = stop_at;
        end else begin
            done_j = last + 1;
        end

        chk("ready_before_start", 32'(ready), 32'd1);
        period = PERIOD_W'(p);
        count  = COUNT_W'(n);
        start  = 1'b1;
        stop   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        stop   = 1'b0;
        period = PERIOD_W'($urandom_range(0, 9));
        count  = COUNT_W'($urandom_range(0, 9));

        for (int j = 1; j <= done_j + 1; j++) begin
            strobe_exp = (n > 0 && j <= last && ((j - 1) % pe) == 0) ? 1 : 0;
            chk($sformatf("strobe_j%0d", j), 32'(strobe), 32'(strobe_exp));
            if (strobe_exp == 1)
                chk($sformatf("idx_j%0d", j), 32'(sample_idx), 32'((j - 1) / pe));
            chk($sformatf("done_j%0d", j), 32'(done), 32'(j == done_j));
            chk($sformatf("busy_j%0d", j), 32'(busy), 32'(n > 0 && j < done_j));
            chk($sformatf("ready_j%0d", j), 32'(ready), 32'(j > done_j));
            chk($sformatf("aborted_j%0d", j), 32'(aborted), 32'((j >= done_j) ? ab_exp : 0));
            if (j <= done_j) begin
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                stop  = (j == stop_at) ? 1'b1
                      : (noise && j == done_j) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
            start = 1'b0;
            stop  = 1'b0;
        end
    endtask

    initial begin
        // Reset values while rst is held
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobe", 32'(strobe), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_idx", 32'(sample_idx), 32'd0);

        release_and_settle();

        // Basic burst, zero-count, zero-period
        burst(3, 4, 0, 1'b0);
        burst(0, 0, 0, 1'b0);
        burst(0, 3, 0, 1'b0);
        // Abort after third strobe (idx 2 at offset 11), then start clears aborted
        burst(5, 10, 11, 1'b0);
        burst(2, 2, 0, 1'b0);
        // Abort on the edge that would produce the last strobe
        burst(2, 3, 4, 1'b0);
        // Start/stop noise during RUN and DONE
        burst(3, 4, 0, 1'b1);
        // Long back-to-back burst
        burst(1, 300, 0, 1'b0);

        // Randomized bursts
        for (int r = 0; r < 25; r++) begin
            int p, n, s, last;
            p    = int'($urandom_range(0, 6));
            n    = int'($urandom_range(0, 7));
            last = (n == 0) ? 0 : 1 + ((p == 0) ? 1 : p) * (n - 1);
            s    = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, last)) : 0;
            burst(p, n, s, 1'b1);
        end

        // Reset mid-burst at idx 4 of 8 (P=2 -> idx 4 at offset 9)
        period = PERIOD_W'(2);
        count  = COUNT_W'(8);
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_strobe", 32'(strobe), 32'd1);
        chk("mid_idx", 32'(sample_idx), 32'd4);
        #1 rst = 1'b1;
        #1;
        chk("async_strobe", 32'(strobe), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_idx", 32'(sample_idx), 32'd0);
        @(negedge clk);
        release_and_settle();
        burst(4, 3, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
